// File: rtl/tiny_alu_pkg.sv
// Shared opcode constants and the master FSM state type for the tiny ALU.
// Opcodes above MUL_OP are undefined; the ALU never answers them.
package tiny_alu_pkg;

  localparam int OPCODE_BITS = 3;

  localparam logic [OPCODE_BITS-1:0] NOP_OP = 3'd0;
  localparam logic [OPCODE_BITS-1:0] ADD_OP = 3'd1;
  localparam logic [OPCODE_BITS-1:0] AND_OP = 3'd2;
  localparam logic [OPCODE_BITS-1:0] XOR_OP = 3'd3;
  localparam logic [OPCODE_BITS-1:0] MUL_OP = 3'd4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } master_state_t;

  function automatic logic is_valid_op(input logic [OPCODE_BITS-1:0] op);
    return (op <= MUL_OP);
  endfunction

endpackage

// File: rtl/tiny_alu_master.sv
// Command master for tiny_alu: accepts one command, starts the ALU, waits for
// done or timeout, then holds the response. Optional TINY_ALU_MASTER_STATS_EN adds counters.
module tiny_alu_master
  import tiny_alu_pkg::*;
#(
  parameter int INPUT_DATA_BITS = 8,
  parameter int TIMEOUT_CYCLES  = 15
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic                         cmd_valid_i,
  output logic                         cmd_ready_o,
  input  logic [OPCODE_BITS-1:0]       cmd_opcode_i,
  input  logic [INPUT_DATA_BITS-1:0]   cmd_a_i,
  input  logic [INPUT_DATA_BITS-1:0]   cmd_b_i,
  output logic                         alu_start_o,
  output logic [OPCODE_BITS-1:0]       alu_opcode_o,
  output logic [INPUT_DATA_BITS-1:0]   alu_a_o,
  output logic [INPUT_DATA_BITS-1:0]   alu_b_o,
  input  logic                         alu_done_i,
  input  logic [2*INPUT_DATA_BITS-1:0] alu_result_i,
  output logic                         rsp_valid_o,
  input  logic                         rsp_ready_i,
  output logic [2*INPUT_DATA_BITS-1:0] rsp_result_o,
  output logic [OPCODE_BITS-1:0]       rsp_opcode_o,
  output logic                         rsp_timeout_o,
  output logic                         busy_o
`ifdef TINY_ALU_MASTER_STATS_EN
  ,
  output logic [15:0]                  op_count_o,
  output logic [15:0]                  timeout_count_o
`endif
);

  // Handshakes: a transfer happens on a rising clk_i edge where valid and
  // ready are both high; valid, once raised, holds its payload until then.

  localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);

  // state_q is the observable FSM state for bound checkers.
  master_state_t                  state_q;
  master_state_t                  state_d;
  logic [7:0]                     wait_cnt_q;
  logic [7:0]                     wait_cnt_d;
  logic [7:0]                     wait_cnt_inc;
  logic [OPCODE_BITS-1:0]         op_q;
  logic [INPUT_DATA_BITS-1:0]     a_q;
  logic [INPUT_DATA_BITS-1:0]     b_q;
  logic [2*INPUT_DATA_BITS-1:0]   result_q;
  logic [OPCODE_BITS-1:0]         rsp_op_q;
  logic                           timeout_q;
  logic                           cap_cmd;
  logic                           cap_done;
  logic                           cap_timeout;
  logic                           rsp_fire;

  assign wait_cnt_inc = wait_cnt_q + 8'd1;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      wait_cnt_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    cap_cmd     = 1'b0;
    cap_done    = 1'b0;
    cap_timeout = 1'b0;
    rsp_fire    = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_valid_i) begin
          cap_cmd = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        wait_cnt_d = 8'd0;
        state_d    = WAIT;
      end
      WAIT: begin
        // done is checked first so a done on the final wait cycle still wins
        if (alu_done_i) begin
          cap_done = 1'b1;
          state_d  = RESP;
        end else if (wait_cnt_inc == TIMEOUT_LIMIT) begin
          cap_timeout = 1'b1;
          wait_cnt_d  = wait_cnt_inc;
          state_d     = RESP;
        end else begin
          wait_cnt_d = wait_cnt_inc;
        end
      end
      RESP: begin
        if (rsp_ready_i) begin
          rsp_fire = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Command registers feed the ALU directly and persist until the next accept.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      op_q <= NOP_OP;
      a_q  <= '0;
      b_q  <= '0;
    end else if (cap_cmd) begin
      op_q <= cmd_opcode_i;
      a_q  <= cmd_a_i;
      b_q  <= cmd_b_i;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      result_q  <= '0;
      rsp_op_q  <= NOP_OP;
      timeout_q <= 1'b0;
    end else if (cap_done) begin
      result_q  <= alu_result_i;
      rsp_op_q  <= op_q;
      timeout_q <= 1'b0;
    end else if (cap_timeout) begin
      result_q  <= '0;
      rsp_op_q  <= op_q;
      timeout_q <= 1'b1;
    end
  end

  assign cmd_ready_o   = (state_q == IDLE) && !reset_i;
  assign alu_start_o   = (state_q == ISSUE);
  assign alu_opcode_o  = op_q;
  assign alu_a_o       = a_q;
  assign alu_b_o       = b_q;
  assign rsp_valid_o   = (state_q == RESP);
  assign rsp_result_o  = result_q;
  assign rsp_opcode_o  = rsp_op_q;
  assign rsp_timeout_o = timeout_q;
  assign busy_o        = (state_q != IDLE);

`ifdef TINY_ALU_MASTER_STATS_EN
  logic [15:0] op_cnt_q;
  logic [15:0] to_cnt_q;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      op_cnt_q <= 16'd0;
      to_cnt_q <= 16'd0;
    end else if (rsp_fire) begin
      if (op_cnt_q != 16'hFFFF) op_cnt_q <= op_cnt_q + 16'd1;
      if (timeout_q && (to_cnt_q != 16'hFFFF)) to_cnt_q <= to_cnt_q + 16'd1;
    end
  end

  assign op_count_o      = op_cnt_q;
  assign timeout_count_o = to_cnt_q;
`endif

endmodule

// File: tb/tb_tiny_alu_master.sv
// Bench for tiny_alu_master: an in-bench ALU responder with programmable done
// delay, a transaction-level model checked every cycle, and directed vectors.
module tb_tiny_alu_master;
  import tiny_alu_pkg::*;

  localparam int W  = 8;
  localparam int TO = 15;

  logic              clk = 1'b0;
  logic              reset_i = 1'b1;
  logic              cmd_valid_i = 1'b0;
  logic              cmd_ready_o;
  logic [2:0]        cmd_opcode_i = 3'd0;
  logic [W-1:0]      cmd_a_i = '0;
  logic [W-1:0]      cmd_b_i = '0;
  logic              alu_start_o;
  logic [2:0]        alu_opcode_o;
  logic [W-1:0]      alu_a_o;
  logic [W-1:0]      alu_b_o;
  logic              alu_done_i = 1'b0;
  logic [2*W-1:0]    alu_result_i = '0;
  logic              rsp_valid_o;
  logic              rsp_ready_i = 1'b1;
  logic [2*W-1:0]    rsp_result_o;
  logic [2:0]        rsp_opcode_o;
  logic              rsp_timeout_o;
  logic              busy_o;
`ifdef TINY_ALU_MASTER_STATS_EN
  logic [15:0]       op_count_o;
  logic [15:0]       timeout_count_o;
`endif

  tiny_alu_master #(.INPUT_DATA_BITS(W), .TIMEOUT_CYCLES(TO)) dut (
    .clk_i(clk), .reset_i(reset_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_opcode_i(cmd_opcode_i), .cmd_a_i(cmd_a_i), .cmd_b_i(cmd_b_i),
    .alu_start_o(alu_start_o), .alu_opcode_o(alu_opcode_o),
    .alu_a_o(alu_a_o), .alu_b_o(alu_b_o),
    .alu_done_i(alu_done_i), .alu_result_i(alu_result_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_result_o(rsp_result_o), .rsp_opcode_o(rsp_opcode_o),
    .rsp_timeout_o(rsp_timeout_o), .busy_o(busy_o)
`ifdef TINY_ALU_MASTER_STATS_EN
    , .op_count_o(op_count_o), .timeout_count_o(timeout_count_o)
`endif
  );

  // clock / reset
  always #5 clk = ~clk;
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish by 100000ns");
    $fatal(1, "watchdog");
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] alu_ref(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      ADD_OP:  return 16'(a) + 16'(b);
      AND_OP:  return {8'h00, a & b};
      XOR_OP:  return {8'h00, a ^ b};
      MUL_OP:  return 16'(a) * 16'(b);
      default: return 16'h0000;
    endcase
  endfunction

  // ALU responder: done arrives alu_delay cycles after the start cycle
  int          alu_delay = 1;
  bit          spur_done = 1'b0;
  int          alu_cnt = 0;
  logic [15:0] alu_pend = '0;

  initial begin
    bit fire;
    forever begin
      @(posedge clk);
      #1;
      fire = 1'b0;
      if (alu_cnt > 0) begin
        alu_cnt--;
        if (alu_cnt == 0) fire = 1'b1;
      end
      alu_done_i   = fire || spur_done;
      alu_result_i = fire ? alu_pend : 16'($urandom);
      @(negedge clk);
      if (alu_start_o && (alu_opcode_o <= MUL_OP)) begin
        alu_cnt  = alu_delay;
        alu_pend = alu_ref(alu_opcode_o, alu_a_o, alu_b_o);
      end
    end
  end

  // Transaction model: age counts cycles since accept (1 = start cycle)
  bit          m_busy = 1'b0;
  int          m_age = 0;
  int          m_resp_at = 0;
  logic [2:0]  m_op = NOP_OP;
  logic [7:0]  m_a = '0, m_b = '0;
  logic [15:0] m_res = '0;
  bit          m_to = 1'b0;
  logic [2:0]  l_op = NOP_OP;
  logic [15:0] l_res = '0;
  bit          l_to = 1'b0;
  int          m_ops = 0, m_tos = 0;
  bit          exp_valid;

  initial begin
    forever begin
      @(negedge clk);
      if (reset_i) begin
        check("rst_alu_start", alu_start_o, 0);
        check("rst_rsp_valid", rsp_valid_o, 0);
        check("rst_rsp_timeout", rsp_timeout_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_rsp_result", rsp_result_o, 0);
        check("rst_alu_a", alu_a_o, 0);
        check("rst_alu_b", alu_b_o, 0);
        check("rst_alu_opcode", alu_opcode_o, NOP_OP);
        check("rst_rsp_opcode", rsp_opcode_o, NOP_OP);
`ifdef TINY_ALU_MASTER_STATS_EN
        check("rst_op_count", op_count_o, 0);
        check("rst_timeout_count", timeout_count_o, 0);
`endif
        m_busy = 0; m_age = 0; m_op = NOP_OP; m_a = 0; m_b = 0;
        l_op = NOP_OP; l_res = 0; l_to = 0; m_ops = 0; m_tos = 0;
      end else begin
        exp_valid = m_busy && (m_age >= m_resp_at);
        check("busy", busy_o, m_busy);
        check("cmd_ready", cmd_ready_o, !m_busy);
        check("alu_start", alu_start_o, m_busy && (m_age == 1));
        check("rsp_valid", rsp_valid_o, exp_valid);
        check("alu_opcode", alu_opcode_o, m_op);
        check("alu_a", alu_a_o, m_a);
        check("alu_b", alu_b_o, m_b);
        check("rsp_result", rsp_result_o, l_res);
        check("rsp_opcode", rsp_opcode_o, l_op);
        check("rsp_timeout", rsp_timeout_o, l_to);
`ifdef TINY_ALU_MASTER_STATS_EN
        check("op_count", op_count_o, m_ops);
        check("timeout_count", timeout_count_o, m_tos);
`endif
        if (!m_busy) begin
          if (cmd_valid_i) begin
            m_busy = 1; m_age = 1;
            m_op = cmd_opcode_i; m_a = cmd_a_i; m_b = cmd_b_i;
            if ((cmd_opcode_i <= MUL_OP) && (alu_delay <= TO)) begin
              m_resp_at = 2 + alu_delay;
              m_res = alu_ref(cmd_opcode_i, cmd_a_i, cmd_b_i);
              m_to = 0;
            end else begin
              m_resp_at = 2 + TO;
              m_res = 0;
              m_to = 1;
            end
          end
        end else if (exp_valid) begin
          if (rsp_ready_i) begin
            m_busy = 0;
            if (m_ops < 16'hFFFF) m_ops++;
            if (l_to && (m_tos < 16'hFFFF)) m_tos++;
          end
        end else begin
          m_age++;
          if (m_age == m_resp_at) begin
            l_res = m_res; l_to = m_to; l_op = m_op;
          end
        end
      end
    end
  end

  // driver tasks
  int unsigned acc_cyc = 0;

  task automatic send_cmd(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    bit ok;
    ok = 0;
    @(posedge clk); #1;
    cmd_valid_i = 1; cmd_opcode_i = op; cmd_a_i = a; cmd_b_i = b;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (cmd_ready_o) begin
        acc_cyc = cyc;
        ok = 1;
        break;
      end
    end
    if (!ok) check("cmd_accept_bound", 0, 1);
    @(posedge clk); #1;
    cmd_valid_i = 0;
    cmd_a_i = 8'($urandom);
    cmd_b_i = 8'($urandom);
  endtask

  task automatic wait_valid(output int lat);
    lat = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (rsp_valid_o) begin
        lat = int'(cyc - acc_cyc);
        break;
      end
    end
    if (lat < 0) check("rsp_valid_bound", 0, 1);
  endtask

  typedef struct packed {
    logic [2:0]  op;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [7:0]  d;
    logic [15:0] res;
    logic        to;
    logic [7:0]  lat;
  } vec_t;

  vec_t vecs [8];

  initial begin
    int lat;
    int unsigned c0, acc2;
    bit seen, ok;

    vecs[0] = '{ADD_OP, 8'd200, 8'd100, 8'd1,  16'd300,   1'b0, 8'd3};
    vecs[1] = '{MUL_OP, 8'hFF,  8'hFF,  8'd1,  16'hFE01,  1'b0, 8'd3};
    vecs[2] = '{AND_OP, 8'hF0,  8'h3C,  8'd3,  16'h0030,  1'b0, 8'd5};
    vecs[3] = '{XOR_OP, 8'hAA,  8'h0F,  8'd2,  16'h00A5,  1'b0, 8'd4};
    vecs[4] = '{3'b111, 8'h12,  8'h34,  8'd1,  16'h0000,  1'b1, 8'd17};
    vecs[5] = '{ADD_OP, 8'hFF,  8'h01,  8'd15, 16'h0100,  1'b0, 8'd17};
    vecs[6] = '{MUL_OP, 8'h10,  8'h10,  8'd16, 16'h0000,  1'b1, 8'd17};
    vecs[7] = '{NOP_OP, 8'h05,  8'h06,  8'd1,  16'h0000,  1'b0, 8'd3};

    reset_i = 1; rsp_ready_i = 1;
    repeat (3) @(posedge clk);
    #1 reset_i = 0;
    @(negedge clk);
    check("ready_after_reset", cmd_ready_o, 1);

    foreach (vecs[i]) begin
      alu_delay = int'(vecs[i].d);
      send_cmd(vecs[i].op, vecs[i].a, vecs[i].b);
      wait_valid(lat);
      check($sformatf("v%0d_latency", i), lat, 32'(vecs[i].lat));
      check($sformatf("v%0d_result", i), rsp_result_o, vecs[i].res);
      check($sformatf("v%0d_timeout", i), rsp_timeout_o, vecs[i].to);
      check($sformatf("v%0d_opcode", i), rsp_opcode_o, vecs[i].op);
    end

    // done pulses while idle must be ignored
    @(negedge clk); spur_done = 1;
    repeat (3) @(negedge clk);
    spur_done = 0;
    check("spur_idle_busy", busy_o, 0);
    check("spur_idle_result", rsp_result_o, 16'h0000);

    // backpressure with a second command already waiting
    @(posedge clk); #1;
    rsp_ready_i = 0;
    alu_delay = 1;
    send_cmd(ADD_OP, 8'd3, 8'd4);
    cmd_valid_i = 1; cmd_opcode_i = XOR_OP; cmd_a_i = 8'h0F; cmd_b_i = 8'hF0;
    wait_valid(lat);
    check("bp_latency", lat, 3);
    repeat (10) begin
      @(negedge clk);
      check("bp_hold_result", rsp_result_o, 16'd7);
      check("bp_hold_ready", cmd_ready_o, 0);
    end
    @(posedge clk); #1;
    rsp_ready_i = 1;
    c0 = cyc;
    ok = 0;
    acc2 = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (cmd_ready_o) begin
        acc2 = cyc;
        ok = 1;
        break;
      end
    end
    check("bp_second_accepted", ok, 1);
    check("bp_second_gap", acc2 - c0, 1);
    acc_cyc = acc2;
    @(posedge clk); #1;
    cmd_valid_i = 0;
    wait_valid(lat);
    check("bp_second_latency", lat, 3);
    check("bp_second_result", rsp_result_o, 16'h00FF);

    // reset in the middle of WAIT, with a done arriving after release
    alu_delay = 8;
    send_cmd(MUL_OP, 8'd9, 8'd9);
    repeat (3) @(posedge clk);
    #1 reset_i = 1;
    #1;
    check("async_rst_busy", busy_o, 0);
    check("async_rst_alu_a", alu_a_o, 0);
    check("async_rst_alu_opcode", alu_opcode_o, NOP_OP);
    check("async_rst_rsp_result", rsp_result_o, 0);
    repeat (2) @(posedge clk);
    #1 reset_i = 0;
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (rsp_valid_o) seen = 1;
    end
    check("no_rsp_after_reset", seen, 0);

    alu_delay = 1;
    send_cmd(ADD_OP, 8'd1, 8'd2);
    wait_valid(lat);
    check("recover_latency", lat, 3);
    check("recover_result", rsp_result_o, 16'd3);
    @(posedge clk); #1;
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
